// File: rtl/adc_spi_reader.sv
// SPI initiator for an LTC2308-style 8-channel 12-bit ADC: CONVST wait, 12-bit shift, one-cycle sample strobe.
// Latency CONV_CYCLES+24*CLK_DIV+1 clk from accepted start to sample_valid; start ignored (dropped) while busy.
module adc_spi_reader #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  channel,
  output logic        busy,
  output logic [11:0] sample,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo
);

  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int PW = $clog2(2 * CLK_DIV);

  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [PW-1:0] P_RISE    = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P_LAST    = PW'(2 * CLK_DIV - 1);
  localparam logic [3:0]    LAST_BIT  = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    SHIFT,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [3:0]    bidx, bidx_nxt;
  logic [11:0]   shreg, shreg_nxt;
  logic [2:0]    cur_ch, cur_ch_nxt;
  logic [2:0]    prev_ch, prev_ch_nxt;
  logic          first_frame, first_nxt;
  logic          convst_nxt, sck_nxt, sdi_nxt;
  logic [11:0]   sample_nxt;
  logic [2:0]    sample_ch_nxt;
  logic          valid_nxt;

  // Config word: single-ended, unipolar, no sleep; bits past the sixth are sent as 0.
  function automatic logic cfg_bit(input logic [2:0] ch, input logic [3:0] k);
    logic [5:0] cfg;
    cfg = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    if (k < 4'd6) begin
      return cfg[3'(4'd5 - k)];
    end
    return 1'b0;
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pcnt_nxt      = pcnt;
    bidx_nxt      = bidx;
    shreg_nxt     = shreg;
    cur_ch_nxt    = cur_ch;
    prev_ch_nxt   = prev_ch;
    first_nxt     = first_frame;
    convst_nxt    = 1'b0;
    sck_nxt       = 1'b0;
    sdi_nxt       = 1'b0;
    sample_nxt    = sample;
    sample_ch_nxt = sample_ch;
    valid_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = CONVERT;
          cur_ch_nxt = channel;
          cnt_nxt    = '0;
          convst_nxt = 1'b1;
        end
      end

      CONVERT: begin
        if (cnt == CONV_LAST) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          pcnt_nxt  = '0;
          bidx_nxt  = '0;
          shreg_nxt = '0;
          sdi_nxt   = cfg_bit(cur_ch, 4'd0);
        end else begin
          cnt_nxt    = cnt + CW'(1);
          convst_nxt = 1'b1;
        end
      end

      SHIFT: begin
        sck_nxt  = adc_sck;
        sdi_nxt  = adc_sdi;
        pcnt_nxt = pcnt + PW'(1);
        if (pcnt == P_RISE) begin
          // SDO is captured on the same edge that raises SCK.
          sck_nxt   = 1'b1;
          shreg_nxt = {shreg[10:0], adc_sdo};
        end else if (pcnt == P_LAST) begin
          pcnt_nxt = '0;
          sck_nxt  = 1'b0;
          if (bidx == LAST_BIT) begin
            state_nxt     = DONE;
            sdi_nxt       = 1'b0;
            sample_nxt    = shreg;
            sample_ch_nxt = prev_ch;
            valid_nxt     = ~first_frame;
          end else begin
            bidx_nxt = bidx + 4'd1;
            sdi_nxt  = cfg_bit(cur_ch, bidx + 4'd1);
          end
        end
      end

      DONE: begin
        // The ADC answers with the previous frame's configuration, so tag data with that channel.
        prev_ch_nxt = cur_ch;
        first_nxt   = 1'b0;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pcnt         <= '0;
      bidx         <= '0;
      shreg        <= '0;
      cur_ch       <= '0;
      prev_ch      <= '0;
      first_frame  <= 1'b1;
      adc_convst   <= 1'b0;
      adc_sck      <= 1'b0;
      adc_sdi      <= 1'b0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pcnt         <= pcnt_nxt;
      bidx         <= bidx_nxt;
      shreg        <= shreg_nxt;
      cur_ch       <= cur_ch_nxt;
      prev_ch      <= prev_ch_nxt;
      first_frame  <= first_nxt;
      adc_convst   <= convst_nxt;
      adc_sck      <= sck_nxt;
      adc_sdi      <= sdi_nxt;
      sample       <= sample_nxt;
      sample_ch    <= sample_ch_nxt;
      sample_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: default timing instance plus a CLK_DIV=1/CONV_CYCLES=1 instance.
module tb_adc_spi_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, f_start;
  logic [2:0]  channel, f_channel;
  logic        busy, sample_valid, adc_convst, adc_sck, adc_sdi, adc_sdo;
  logic [11:0] sample;
  logic [2:0]  sample_ch;
  logic        f_busy, f_sample_valid, f_convst, f_sck, f_sdi, f_sdo;
  logic [11:0] f_sample;
  logic [2:0]  f_sample_ch;

  adc_spi_reader dut (
    .clk(clk), .reset(reset), .start(start), .channel(channel), .busy(busy),
    .sample(sample), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo)
  );

  adc_spi_reader #(.CLK_DIV(1), .CONV_CYCLES(1)) dut_fast (
    .clk(clk), .reset(reset), .start(f_start), .channel(f_channel), .busy(f_busy),
    .sample(f_sample), .sample_ch(f_sample_ch), .sample_valid(f_sample_valid),
    .adc_convst(f_convst), .adc_sck(f_sck), .adc_sdi(f_sdi), .adc_sdo(f_sdo)
  );

  // ADC models: load the word when CONVST falls, shift one bit out per SCK falling edge.
  logic [11:0] adc_word = '0, a_sreg = '0, f_word = '0, f_sreg = '0;
  logic a_cv_d = 1'b0, a_sck_d = 1'b0, f_cv_d = 1'b0, f_sck_d = 1'b0;
  assign adc_sdo = a_sreg[11];
  assign f_sdo   = f_sreg[11];

  always @(negedge clk) begin
    if (a_cv_d && !adc_convst) a_sreg <= adc_word;
    else if (a_sck_d && !adc_sck) a_sreg <= {a_sreg[10:0], 1'b0};
    a_cv_d  <= adc_convst;
    a_sck_d <= adc_sck;
    if (f_cv_d && !f_convst) f_sreg <= f_word;
    else if (f_sck_d && !f_sck) f_sreg <= {f_sreg[10:0], 1'b0};
    f_cv_d  <= f_convst;
    f_sck_d <= f_sck;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  int          cap_cv_cnt, cap_cv_first, cap_cv_last, cap_rises, cap_hi, cap_sdi_bad;
  int          cap_vcnt, cap_vcyc1, cap_vcyc2, cap_busy_last, cap_idle_valid;
  logic [11:0] cap_sdi, cap_s1, cap_s2;
  logic [2:0]  cap_c1, cap_c2;

  // Observes cycles 1..ncyc (cycle n = interval after the nth edge following start).
  // mode 0: single start pulse; mode 1: continuous schedule; mode 2: start/channel poked mid-SHIFT.
  task automatic capture(input bit fast, input int ncyc, input int mode);
    logic cv, sck, sdi, vld, bsy, psck, psdi;
    logic [11:0] smp;
    logic [2:0]  sch;
    cap_cv_cnt = 0; cap_cv_first = -1; cap_cv_last = -1; cap_rises = 0; cap_hi = 0;
    cap_sdi_bad = 0; cap_vcnt = 0; cap_vcyc1 = -1; cap_vcyc2 = -1; cap_busy_last = -1;
    cap_idle_valid = 0; cap_sdi = '0; cap_s1 = '0; cap_s2 = '0; cap_c1 = '0; cap_c2 = '0;
    psck = 1'b0; psdi = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      cv  = fast ? f_convst : adc_convst;
      sck = fast ? f_sck : adc_sck;
      sdi = fast ? f_sdi : adc_sdi;
      vld = fast ? f_sample_valid : sample_valid;
      bsy = fast ? f_busy : busy;
      smp = fast ? f_sample : sample;
      sch = fast ? f_sample_ch : sample_ch;
      if (cv) begin
        cap_cv_cnt++;
        if (cap_cv_first < 0) cap_cv_first = cyc;
        cap_cv_last = cyc;
      end
      if (sck && !psck) begin
        cap_rises++;
        cap_sdi = {cap_sdi[10:0], sdi};
      end
      if (sck) cap_hi++;
      if (sck && sdi != psdi) cap_sdi_bad++;
      if (vld) begin
        cap_vcnt++;
        if (cap_vcnt == 1) begin cap_vcyc1 = cyc; cap_s1 = smp; cap_c1 = sch; end
        else begin cap_vcyc2 = cyc; cap_s2 = smp; cap_c2 = sch; end
        if (!bsy) cap_idle_valid++;
      end
      if (bsy) cap_busy_last = cyc;
      psck = sck;
      psdi = sdi;
      case (mode)
        0: if (cyc == 1) begin if (fast) f_start = 1'b0; else start = 1'b0; end
        1: begin
          if (cyc == 100) channel = 3'd7;
          if (cyc == 131) adc_word = 12'hFFF;
          if (cyc == 200) channel = 3'd4;
          if (cyc == 261) adc_word = 12'h800;
          if (cyc == 300) start = 1'b0;
        end
        default: begin
          if (cyc == 1) start = 1'b0;
          if (cyc == 100) begin start = 1'b1; channel = 3'd6; end
          if (cyc == 105) start = 1'b0;
        end
      endcase
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] word;
    logic        exp_vld;
    logic [11:0] exp_sample;
    logic [2:0]  exp_ch;
    logic [11:0] exp_sdi;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd3, 12'hA5C, 1'b0, 12'h000, 3'd0, 12'b1101_1000_0000};
    vecs[1] = '{3'd5, 12'hA5C, 1'b1, 12'hA5C, 3'd3, 12'b1110_1000_0000};
    vecs[2] = '{3'd0, 12'h123, 1'b1, 12'h123, 3'd5, 12'b1000_1000_0000};
    vecs[3] = '{3'd6, 12'h7E1, 1'b1, 12'h7E1, 3'd0, 12'b1011_1000_0000};

    reset = 1'b1; start = 1'b0; channel = '0; f_start = 1'b0; f_channel = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_sample_ch", 32'(sample_ch), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_convst", 32'(adc_convst), 32'd0);
    chk("rst_sck", 32'(adc_sck), 32'd0);
    chk("rst_sdi", 32'(adc_sdi), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      channel = vecs[i].ch;
      adc_word = vecs[i].word;
      start = 1'b1;
      capture(1'b0, 135, 0);
      chk($sformatf("v%0d_convst_cnt", i), 32'(cap_cv_cnt), 32'd80);
      chk($sformatf("v%0d_convst_first", i), 32'(cap_cv_first), 32'd1);
      chk($sformatf("v%0d_convst_last", i), 32'(cap_cv_last), 32'd80);
      chk($sformatf("v%0d_sck_rises", i), 32'(cap_rises), 32'd12);
      chk($sformatf("v%0d_sck_high", i), 32'(cap_hi), 32'd24);
      chk($sformatf("v%0d_sdi_bits", i), 32'(cap_sdi), 32'(vecs[i].exp_sdi));
      chk($sformatf("v%0d_sdi_stable", i), 32'(cap_sdi_bad), 32'd0);
      chk($sformatf("v%0d_busy_last", i), 32'(cap_busy_last), 32'd129);
      chk($sformatf("v%0d_valid_cnt", i), 32'(cap_vcnt), 32'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) begin
        chk($sformatf("v%0d_valid_cyc", i), 32'(cap_vcyc1), 32'd129);
        chk($sformatf("v%0d_sample", i), 32'(cap_s1), 32'(vecs[i].exp_sample));
        chk($sformatf("v%0d_sample_ch", i), 32'(cap_c1), 32'(vecs[i].exp_ch));
      end
    end

    // Continuous frames after reset: first discarded, then 130-cycle strobe spacing.
    do_reset();
    channel = 3'd2;
    adc_word = 12'h001;
    start = 1'b1;
    capture(1'b0, 420, 1);
    chk("cont_convst_cnt", 32'(cap_cv_cnt), 32'd240);
    chk("cont_valid_cnt", 32'(cap_vcnt), 32'd2);
    chk("cont_valid_cyc1", 32'(cap_vcyc1), 32'd259);
    chk("cont_sample1", 32'(cap_s1), 32'hFFF);
    chk("cont_ch1", 32'(cap_c1), 32'd2);
    chk("cont_valid_cyc2", 32'(cap_vcyc2), 32'd389);
    chk("cont_sample2", 32'(cap_s2), 32'h800);
    chk("cont_ch2", 32'(cap_c2), 32'd7);
    chk("cont_idle_valid", 32'(cap_idle_valid), 32'd0);

    // Start and channel poked mid-SHIFT are ignored.
    channel = 3'd1;
    adc_word = 12'h3C3;
    start = 1'b1;
    capture(1'b0, 260, 2);
    chk("mid_convst_cnt", 32'(cap_cv_cnt), 32'd80);
    chk("mid_sdi_bits", 32'(cap_sdi), 32'b1100_1000_0000);
    chk("mid_busy_last", 32'(cap_busy_last), 32'd129);
    chk("mid_valid_cnt", 32'(cap_vcnt), 32'd1);
    chk("mid_sample", 32'(cap_s1), 32'h3C3);
    chk("mid_sample_ch", 32'(cap_c1), 32'd4);

    // Reset during the high half of SCK period 6.
    channel = 3'd2;
    adc_word = 12'h555;
    start = 1'b1;
    for (int cyc = 1; cyc <= 107; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    chk("pre_rst_sck", 32'(adc_sck), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_sck", 32'(adc_sck), 32'd0);
    chk("mid_rst_convst", 32'(adc_convst), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sample", 32'(sample), 32'd0);
    chk("mid_rst_sample_ch", 32'(sample_ch), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    channel = 3'd3;
    adc_word = 12'h0F0;
    start = 1'b1;
    capture(1'b0, 135, 0);
    chk("post_rst_valid_cnt", 32'(cap_vcnt), 32'd0);
    chk("post_rst_convst_cnt", 32'(cap_cv_cnt), 32'd80);
    chk("post_rst_sdi_bits", 32'(cap_sdi), 32'b1101_1000_0000);

    // Minimum timing instance.
    f_channel = 3'd1;
    f_word = 12'hABC;
    f_start = 1'b1;
    capture(1'b1, 30, 0);
    chk("fast1_valid_cnt", 32'(cap_vcnt), 32'd0);
    chk("fast1_busy_last", 32'(cap_busy_last), 32'd26);
    f_channel = 3'd2;
    f_word = 12'h5A3;
    f_start = 1'b1;
    capture(1'b1, 30, 0);
    chk("fast2_convst_cnt", 32'(cap_cv_cnt), 32'd1);
    chk("fast2_sck_rises", 32'(cap_rises), 32'd12);
    chk("fast2_sck_high", 32'(cap_hi), 32'd12);
    chk("fast2_sdi_bits", 32'(cap_sdi), 32'b1001_1000_0000);
    chk("fast2_valid_cyc", 32'(cap_vcyc1), 32'd26);
    chk("fast2_sample", 32'(cap_s1), 32'h5A3);
    chk("fast2_sample_ch", 32'(cap_c1), 32'd1);
    chk("fast2_busy_last", 32'(cap_busy_last), 32'd26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- SPI initiator for the board's 8-channel 12-bit ADC (LTC2308-style: CONVST, SCK, SDI, SDO).
- Starts a conversion, clocks in the 12-bit result and presents it to the max-voltage register/comparator path as a one-cycle-valid sample with its channel tag.
- Sits between the ADC pins and the tracking datapath; it supplies the ADC voltage values that the datapath receives.

Parameters:
- CLK_DIV, 2, clk cycles per SCK half-period (>=1)
- CONV_CYCLES, 80, clk cycles CONVST is held high for the conversion wait (>=1; 1.6 us at 50 MHz)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- start  input  1  request a frame; sampled only in IDLE; held high = continuous back-to-back frames
- channel  input  3  ADC channel to configure; latched when start is accepted
- busy  output  1  high in every state except IDLE
- sample  output  12  last received result, MSB first off SDO; holds until the next valid
- sample_ch  output  3  channel that `sample` belongs to
- sample_valid  output  1  one-cycle strobe: sample/sample_ch updated
- adc_convst  output  1  ADC conversion start
- adc_sck  output  1  SPI clock, idles low
- adc_sdi  output  1  config word to ADC
- adc_sdo  input  1  data from ADC

Behaviour:
- Reset values: busy=0, sample=0, sample_ch=0, sample_valid=0, adc_convst=0, adc_sck=0, adc_sdi=0, state=IDLE, first_frame=1, prev_ch=0.
- FSM states are IDLE, CONVERT, SHIFT, DONE.
- IDLE -> CONVERT: when start=1 on a clk edge (cycle 0).
  - Latch `channel` into cur_ch.
  - Build cfg[5:0] = {1, cur_ch[0], cur_ch[2], cur_ch[1], 1, 0}: single-ended, unipolar, no sleep.
- CONVERT: adc_convst=1 for exactly CONV_CYCLES cycles (cycles 1..CONV_CYCLES), then go to SHIFT with adc_convst=0.
- SHIFT: 12 SCK periods, each 2*CLK_DIV cycles (low half first, then high half), for 24*CLK_DIV cycles in total.
  - adc_sdi carries bit k (k=0..11) for all of period k.
  - Bit k = cfg[5-k] for k<6, and 0 for k>=6.
  - adc_sdi changes only at period boundaries, i.e. on the SCK falling edge or at SHIFT entry.
  - adc_sdo is sampled on the clk edge where adc_sck goes 0->1 and shifted into shreg LSB-in; the first sample is the MSB.
  - After the last high half, adc_sck returns low and the FSM enters DONE.
- DONE (1 cycle, cycle CONV_CYCLES+24*CLK_DIV+1):
  - If first_frame=0: sample<=shreg, sample_ch<=prev_ch, sample_valid=1.
  - If first_frame=1: sample_valid stays 0 and the frame is discarded. The ADC returns the previous frame's configured conversion, so the first frame has no valid data.
  - In both cases: prev_ch<=cur_ch, first_frame<=0, go to IDLE.
- Frame latency with defaults: start sampled at cycle 0 -> sample_valid at cycle 129.
  - In continuous mode the next frame begins at cycle 130 (IDLE lasts 1 cycle).
- sample_valid is high for exactly one cycle per accepted non-first frame and is never high while in IDLE.
- Inputs during a frame:
  - start and channel are ignored while busy=1.
  - A start pulse during busy is dropped, not queued.
- reset asserted mid-frame: all outputs take their reset values immediately (asynchronously). adc_convst and adc_sck drop at once, the partial frame is lost, first_frame=1 again.
- Counter widths: sized by $clog2 of CONV_CYCLES and 2*CLK_DIV; no wrap occurs inside a frame.

Test Plan:
- Reset then start=1 for one cycle, channel=3, ADC model drives 12'hA5C -> adc_convst high for exactly 80 cycles, 12 SCK pulses of 4 clk each, SDI bits 1,1,0,1,1,0,0,0,0,0,0,0, no sample_valid (first frame); busy falls after cycle 129.
- Second frame with channel=5, model returns 12'hA5C -> sample_valid pulse at cycle 129 of that frame, sample=12'hA5C, sample_ch=3; SDI config 111010.
- start held high for 3 frames, model returns 12'h001, 12'hFFF, 12'h800 -> valid strobes exactly 130 cycles apart; values 12'hFFF and 12'h800 reported with the correct previous channel.
- start pulsed and channel changed mid-SHIFT -> no extra frame starts and the SDI config is unchanged.
- reset asserted during SHIFT bit 6 -> adc_sck=0, adc_convst=0, busy=0 in the same cycle; the next frame produces no sample_valid.
- CLK_DIV=1, CONV_CYCLES=1 -> sample_valid at cycle 26; SCK period is 2 clk.
